// File: rtl/axi4_arb_pkg.sv
// Shared types and constants for the AXI4 arbiters (read path now, write path later).
// Burst encodings live here so both paths and their benches agree on them.
package axi4_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Counters are wide enough for the largest supported outstanding limit (15).
  localparam int CNT_W = 4;

  // Index width, never zero so the prepended ID field always exists.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi4_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// Shared by the read- and write-path arbiters.
module axi4_rr_arbiter
  import axi4_arb_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [IDX_W:0] cand;
  logic           found;

  // The extra bit on cand lets the sum exceed N before folding back into range.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        gnt_o[cand[IDX_W-1:0]]   = 1'b1;
        gnt_idx_o                = cand[IDX_W-1:0];
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 read path between N_INIT initiators: round-robin AR arbitration with
// the initiator index prepended to ARID, R beats routed back by the upper RID bits.
module axi4_rd_arbiter
  import axi4_arb_pkg::*;
#(
  parameter  int N_INIT          = 2,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 64,
  parameter  int ID_WIDTH        = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int IDX_W           = idx_width(N_INIT),
  localparam int TID_W           = ID_WIDTH + IDX_W
) (
  input  logic                         clock,
  input  logic                         reset,
  // initiator side
  input  logic [N_INIT-1:0]            i_ARVALID,
  output logic [N_INIT-1:0]            i_ARREADY,
  input  logic [N_INIT*ADDR_WIDTH-1:0] i_ARADDR,
  input  logic [N_INIT*ID_WIDTH-1:0]   i_ARID,
  input  logic [N_INIT*8-1:0]          i_ARLEN,
  input  logic [N_INIT*3-1:0]          i_ARSIZE,
  input  logic [N_INIT*2-1:0]          i_ARBURST,
  output logic [N_INIT-1:0]            i_RVALID,
  input  logic [N_INIT-1:0]            i_RREADY,
  output logic [ID_WIDTH-1:0]          i_RID,
  output logic [DATA_WIDTH-1:0]        i_RDATA,
  output logic [1:0]                   i_RRESP,
  output logic                         i_RLAST,
  // target side
  output logic                         o_ARVALID,
  input  logic                         o_ARREADY,
  output logic [ADDR_WIDTH-1:0]        o_ARADDR,
  output logic [TID_W-1:0]             o_ARID,
  output logic [7:0]                   o_ARLEN,
  output logic [2:0]                   o_ARSIZE,
  output logic [1:0]                   o_ARBURST,
  input  logic                         o_RVALID,
  output logic                         o_RREADY,
  input  logic [TID_W-1:0]             o_RID,
  input  logic [DATA_WIDTH-1:0]        o_RDATA,
  input  logic [1:0]                   o_RRESP,
  input  logic                         o_RLAST,
  output logic                         rid_err
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INIT - 1);

  ar_state_e              state_q;
  logic [IDX_W-1:0]       grantIdx_q;
  logic [IDX_W-1:0]       rrPtr_q;
  logic                   arValid_q;
  logic [ADDR_WIDTH-1:0]  arAddr_q;
  logic [TID_W-1:0]       arId_q;
  logic [7:0]             arLen_q;
  logic [2:0]             arSize_q;
  logic [1:0]             arBurst_q;
  logic [CNT_W-1:0]       cnt_q [N_INIT];
  logic [CNT_W-1:0]       cnt_d [N_INIT];
  logic                   ridErr_q;
  logic                   ridErr_d;

  logic [N_INIT-1:0]      eligible;
  logic [N_INIT-1:0]      gnt;
  logic [IDX_W-1:0]       gntIdx;
  logic                   gntValid;
  logic [ADDR_WIDTH-1:0]  selAddr;
  logic [ID_WIDTH-1:0]    selId;
  logic [7:0]             selLen;
  logic [2:0]             selSize;
  logic [1:0]             selBurst;

  logic [IDX_W-1:0]       ridIdx;
  logic                   ridHit;
  logic                   rHs;
  logic [N_INIT-1:0]      arInc;
  logic [N_INIT-1:0]      rDec;

  // Requests only compete while idle and below their in-flight limit.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < N_INIT; k++) begin
      eligible[k] = i_ARVALID[k] && (cnt_q[k] < MAX_CNT) && (state_q == IDLE) && !reset;
    end
  end

  axi4_rr_arbiter #(
    .N (N_INIT)
  ) u_rr (
    .req_i       (eligible),
    .ptr_i       (rrPtr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gntIdx),
    .gnt_valid_o (gntValid)
  );

  assign i_ARREADY = gnt;

  always_comb begin
    selAddr  = '0;
    selId    = '0;
    selLen   = '0;
    selSize  = '0;
    selBurst = '0;
    for (int k = 0; k < N_INIT; k++) begin
      if (gnt[k]) begin
        selAddr  = i_ARADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
        selId    = i_ARID[k*ID_WIDTH +: ID_WIDTH];
        selLen   = i_ARLEN[k*8 +: 8];
        selSize  = i_ARSIZE[k*3 +: 3];
        selBurst = i_ARBURST[k*2 +: 2];
      end
    end
  end

  // R routing is purely combinational; unknown indices are swallowed by the target ready.
  assign ridIdx = o_RID[TID_W-1 -: IDX_W];

  always_comb begin
    i_RVALID = '0;
    o_RREADY = 1'b1;
    ridHit   = 1'b0;
    for (int k = 0; k < N_INIT; k++) begin
      if (ridIdx == IDX_W'(k)) begin
        ridHit      = 1'b1;
        i_RVALID[k] = o_RVALID;
        o_RREADY    = i_RREADY[k];
      end
    end
  end

  assign i_RID   = o_RID[ID_WIDTH-1:0];
  assign i_RDATA = o_RDATA;
  assign i_RRESP = o_RRESP;
  assign i_RLAST = o_RLAST;

  // A burst completing on an idle counter is a target error; the counter must not wrap.
  always_comb begin
    ridErr_d = ridErr_q;
    rHs      = o_RVALID && o_RREADY;
    arInc    = '0;
    rDec     = '0;
    if (rHs && !ridHit) begin
      ridErr_d = 1'b1;
    end
    for (int k = 0; k < N_INIT; k++) begin
      arInc[k] = (state_q == ISSUE) && o_ARREADY && (grantIdx_q == IDX_W'(k));
      rDec[k]  = rHs && o_RLAST && ridHit && (ridIdx == IDX_W'(k));
      cnt_d[k] = cnt_q[k];
      if (rDec[k] && (cnt_q[k] == '0)) begin
        ridErr_d = 1'b1;
        if (arInc[k]) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end else if (arInc[k] && !rDec[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else if (rDec[k] && !arInc[k]) begin
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grantIdx_q <= '0;
      rrPtr_q    <= '0;
      arValid_q  <= 1'b0;
      arAddr_q   <= '0;
      arId_q     <= '0;
      arLen_q    <= '0;
      arSize_q   <= '0;
      arBurst_q  <= '0;
      ridErr_q   <= 1'b0;
      for (int k = 0; k < N_INIT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      ridErr_q <= ridErr_d;
      for (int k = 0; k < N_INIT; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      case (state_q)
        IDLE: begin
          if (gntValid) begin
            state_q    <= ISSUE;
            arValid_q  <= 1'b1;
            grantIdx_q <= gntIdx;
            arAddr_q   <= selAddr;
            arId_q     <= {gntIdx, selId};
            arLen_q    <= selLen;
            arSize_q   <= selSize;
            arBurst_q  <= selBurst;
          end
        end
        ISSUE: begin
          if (o_ARREADY) begin
            state_q   <= IDLE;
            arValid_q <= 1'b0;
            rrPtr_q   <= (grantIdx_q == LAST_IDX) ? '0 : grantIdx_q + IDX_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          arValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ARVALID = arValid_q;
  assign o_ARADDR  = arAddr_q;
  assign o_ARID    = arId_q;
  assign o_ARLEN   = arLen_q;
  assign o_ARSIZE  = arSize_q;
  assign o_ARBURST = arBurst_q;
  assign rid_err   = ridErr_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Bench for axi4_rd_arbiter with three initiators: R routing table, directed corner
// sequences, then randomized traffic against a transaction-level model.
module tb_axi4_rd_arbiter;
  import axi4_arb_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int MAX = 4;
  localparam int TW  = IW + 2;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0]    i_ARVALID, i_ARREADY, i_RVALID, i_RREADY;
  logic [N*AW-1:0] i_ARADDR;
  logic [N*IW-1:0] i_ARID;
  logic [N*8-1:0]  i_ARLEN;
  logic [N*3-1:0]  i_ARSIZE;
  logic [N*2-1:0]  i_ARBURST;
  logic [IW-1:0]   i_RID;
  logic [DW-1:0]   i_RDATA;
  logic [1:0]      i_RRESP;
  logic            i_RLAST;
  logic            o_ARVALID, o_ARREADY;
  logic [AW-1:0]   o_ARADDR;
  logic [TW-1:0]   o_ARID;
  logic [7:0]      o_ARLEN;
  logic [2:0]      o_ARSIZE;
  logic [1:0]      o_ARBURST;
  logic            o_RVALID, o_RREADY;
  logic [TW-1:0]   o_RID;
  logic [DW-1:0]   o_RDATA;
  logic [1:0]      o_RRESP;
  logic            o_RLAST;
  logic            rid_err;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  axi4_rd_arbiter #(
    .N_INIT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .i_ARVALID(i_ARVALID), .i_ARREADY(i_ARREADY), .i_ARADDR(i_ARADDR), .i_ARID(i_ARID),
    .i_ARLEN(i_ARLEN), .i_ARSIZE(i_ARSIZE), .i_ARBURST(i_ARBURST),
    .i_RVALID(i_RVALID), .i_RREADY(i_RREADY), .i_RID(i_RID), .i_RDATA(i_RDATA),
    .i_RRESP(i_RRESP), .i_RLAST(i_RLAST),
    .o_ARVALID(o_ARVALID), .o_ARREADY(o_ARREADY), .o_ARADDR(o_ARADDR), .o_ARID(o_ARID),
    .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE), .o_ARBURST(o_ARBURST),
    .o_RVALID(o_RVALID), .o_RREADY(o_RREADY), .o_RID(o_RID), .o_RDATA(o_RDATA),
    .o_RRESP(o_RRESP), .o_RLAST(o_RLAST),
    .rid_err(rid_err)
  );

  typedef struct {
    logic          rvalid;
    logic [TW-1:0] rid;
    logic [N-1:0]  rready;
    logic [N-1:0]  expRvalid;
    logic          expRready;
  } route_vec_t;

  typedef struct {
    logic [TW-1:0] id;
    int            len;
  } burst_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    i_ARVALID = '0; i_ARADDR = '0; i_ARID = '0; i_ARLEN = '0; i_ARSIZE = '0; i_ARBURST = '0;
    i_RREADY = '0; o_ARREADY = 1'b0; o_RVALID = 1'b0; o_RID = '0; o_RDATA = '0;
    o_RRESP = '0; o_RLAST = 1'b0;
  endtask

  task automatic resetDut();
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic setAr(input int k, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                       input logic [7:0] len);
    i_ARADDR[k*AW +: AW] = addr;
    i_ARID[k*IW +: IW]   = id;
    i_ARLEN[k*8 +: 8]    = len;
    i_ARSIZE[k*3 +: 3]   = 3'd3;
    i_ARBURST[k*2 +: 2]  = BURST_INCR;
  endtask

  task automatic applyStimulus(input logic valid, input logic [TW-1:0] rid, input logic last,
                               input logic [N-1:0] rready);
    o_RVALID = valid;
    o_RID    = rid;
    o_RLAST  = last;
    o_RDATA  = {32'hD00D_0000, 26'd0, rid};
    i_RREADY = rready;
  endtask

  // Transaction-level model state for the randomized phase.
  int     mCnt [N];
  int     mPtr, mIdx, mLen, win, rIdx, beat, cand;
  bit     mBusy, rActive, expRr, rHs;
  logic [AW-1:0] mAddr;
  logic [TW-1:0] mId;
  logic [N-1:0]  expReady, expRv;
  burst_t tq[$];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    route_vec_t routeTab [7];
    routeTab[0] = '{1'b1, 6'h03, 3'b001, 3'b001, 1'b1};
    routeTab[1] = '{1'b1, 6'h15, 3'b001, 3'b010, 1'b0};
    routeTab[2] = '{1'b1, 6'h15, 3'b010, 3'b010, 1'b1};
    routeTab[3] = '{1'b1, 6'h20, 3'b011, 3'b100, 1'b0};
    routeTab[4] = '{1'b1, 6'h2F, 3'b100, 3'b100, 1'b1};
    routeTab[5] = '{1'b0, 6'h00, 3'b111, 3'b000, 1'b1};
    routeTab[6] = '{1'b0, 6'h10, 3'b101, 3'b000, 1'b0};

    // Reset state, with requests pending so a stray grant would show up.
    clearInputs();
    reset = 1'b1;
    i_ARVALID = '1;
    tick();
    tick();
    #3;
    checkOutput("rst_arready", i_ARREADY, 0);
    checkOutput("rst_arvalid", o_ARVALID, 0);
    checkOutput("rst_araddr", o_ARADDR, 0);
    checkOutput("rst_arid", o_ARID, 0);
    checkOutput("rst_riderr", rid_err, 0);
    for (int k = 0; k < N; k++) checkOutput("rst_cnt", dut.cnt_q[k], 0);
    reset = 1'b0;
    i_ARVALID = '0;
    tick();

    for (int v = 0; v < 7; v++) begin
      applyStimulus(routeTab[v].rvalid, routeTab[v].rid, 1'b0, routeTab[v].rready);
      #3;
      checkOutput("route_rvalid", i_RVALID, routeTab[v].expRvalid);
      checkOutput("route_rready", o_RREADY, routeTab[v].expRready);
      checkOutput("route_rid", i_RID, routeTab[v].rid[IW-1:0]);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    #3;
    checkOutput("route_riderr", rid_err, 0);

    // 1: single burst from initiator 0.
    resetDut();
    setAr(0, 32'h100, 4'h3, 8'd3);
    i_ARVALID = 3'b001;
    #3;
    checkOutput("t1_arready", i_ARREADY, 3'b001);
    tick();
    i_ARVALID = '0;
    o_ARREADY = 1'b1;
    #3;
    checkOutput("t1_arvalid", o_ARVALID, 1);
    checkOutput("t1_arid", o_ARID, 6'h03);
    checkOutput("t1_araddr", o_ARADDR, 32'h100);
    checkOutput("t1_arlen", o_ARLEN, 3);
    tick();
    o_ARREADY = 1'b0;
    #3;
    checkOutput("t1_arvalid_low", o_ARVALID, 0);
    checkOutput("t1_cnt_up", dut.cnt_q[0], 1);
    for (int b = 0; b < 4; b++) begin
      tick();
      applyStimulus(1'b1, 6'h03, (b == 3), 3'b011);
      #3;
      checkOutput("t1_rvalid", i_RVALID, 3'b001);
      checkOutput("t1_rready", o_RREADY, 1);
    end
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    #3;
    checkOutput("t1_cnt_down", dut.cnt_q[0], 0);

    // 2: contention between initiators 0 and 1 alternates grants.
    resetDut();
    setAr(0, 32'h200, 4'h1, 8'd0);
    setAr(1, 32'h300, 4'h2, 8'd0);
    i_ARVALID = 3'b011;
    o_ARREADY = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #3;
      checkOutput("t2_grant", i_ARREADY, (g % 2 == 0) ? 3'b001 : 3'b010);
      tick();
      #3;
      checkOutput("t2_arid_idx", o_ARID[TW-1 -: 2], g % 2);
      tick();
    end

    // 3: outstanding limit on initiator 1, released by one RLAST.
    resetDut();
    setAr(0, 32'h400, 4'h4, 8'd0);
    setAr(1, 32'h500, 4'h5, 8'd0);
    i_ARVALID = 3'b010;
    o_ARREADY = 1'b1;
    for (int g = 0; g < MAX; g++) begin
      #3;
      checkOutput("t3_fill", i_ARREADY, 3'b010);
      tick();
      tick();
    end
    i_ARVALID = 3'b011;
    #3;
    checkOutput("t3_init0_wins", i_ARREADY, 3'b001);
    tick();
    tick();
    i_ARVALID = 3'b010;
    #3;
    checkOutput("t3_stalled", i_ARREADY, 3'b000);
    tick();
    applyStimulus(1'b1, 6'h15, 1'b1, 3'b010);
    #3;
    checkOutput("t3_still_full", i_ARREADY, 3'b000);
    checkOutput("t3_rvalid", i_RVALID, 3'b010);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    #3;
    checkOutput("t3_released", i_ARREADY, 3'b010);

    // 4: target AR and initiator R backpressure.
    resetDut();
    setAr(0, 32'hABC0, 4'h5, 8'd1);
    i_ARVALID = 3'b001;
    tick();
    setAr(0, 32'hFFF0, 4'h9, 8'd7);
    i_ARVALID = 3'b011;
    applyStimulus(1'b1, 6'h05, 1'b0, 3'b000);
    for (int c = 0; c < 5; c++) begin
      #3;
      checkOutput("t4_arvalid", o_ARVALID, 1);
      checkOutput("t4_addr_hold", o_ARADDR, 32'hABC0);
      checkOutput("t4_id_hold", o_ARID, 6'h05);
      checkOutput("t4_no_grant", i_ARREADY, 0);
      checkOutput("t4_rready", o_RREADY, 0);
      checkOutput("t4_rvalid", i_RVALID, 3'b001);
      tick();
    end
    o_ARREADY = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick();
    o_ARREADY = 1'b0;
    i_ARVALID = '0;
    #3;
    checkOutput("t4_cnt", dut.cnt_q[0], 1);

    // 5: AR handshake and RLAST for initiator 0 in the same cycle.
    resetDut();
    setAr(0, 32'h600, 4'h3, 8'd0);
    i_ARVALID = 3'b001;
    o_ARREADY = 1'b1;
    tick(); tick(); tick(); tick();
    #3;
    checkOutput("t5_cnt_pre", dut.cnt_q[0], 2);
    tick();
    applyStimulus(1'b1, 6'h03, 1'b1, 3'b001);
    tick();
    i_ARVALID = '0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    #3;
    checkOutput("t5_cnt_same", dut.cnt_q[0], 2);

    // 6: out-of-range RID index, then reset while issuing.
    resetDut();
    applyStimulus(1'b1, 6'h37, 1'b1, 3'b000);
    #3;
    checkOutput("t6_drop_rready", o_RREADY, 1);
    checkOutput("t6_drop_rvalid", i_RVALID, 0);
    checkOutput("t6_riderr_pre", rid_err, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    #3;
    checkOutput("t6_riderr", rid_err, 1);
    setAr(2, 32'h700, 4'hA, 8'd2);
    i_ARVALID = 3'b100;
    o_ARREADY = 1'b1;
    tick();
    tick();
    o_ARREADY = 1'b0;
    tick();
    #3;
    checkOutput("t6_issuing", o_ARVALID, 1);
    checkOutput("t6_cnt_pre", dut.cnt_q[2], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_ARVALID = '0;
    #3;
    checkOutput("t6_rst_arvalid", o_ARVALID, 0);
    checkOutput("t6_rst_cnt", dut.cnt_q[2], 0);
    checkOutput("t6_rst_riderr", rid_err, 0);

    // Randomized traffic against the transaction model.
    resetDut();
    for (int k = 0; k < N; k++) mCnt[k] = 0;
    mPtr = 0; mBusy = 0; mIdx = 0; mLen = 0; mAddr = '0; mId = '0;
    rActive = 0; beat = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < N; k++) begin
        setAr(k, $urandom, 4'($urandom), 8'($urandom_range(0, 2)));
      end
      i_ARVALID = N'($urandom);
      o_ARREADY = 1'($urandom_range(0, 1));
      i_RREADY  = N'($urandom);
      if (!rActive && tq.size() > 0 && $urandom_range(0, 2) != 0) rActive = 1;
      if (rActive) applyStimulus(1'b1, tq[0].id, (beat == tq[0].len), i_RREADY);
      else applyStimulus(1'b0, '0, 1'b0, i_RREADY);
      #3;

      win = -1;
      if (!mBusy) begin
        for (int i = 0; i < N; i++) begin
          cand = (mPtr + i) % N;
          if (win < 0 && i_ARVALID[cand] && mCnt[cand] < MAX) win = cand;
        end
      end
      expReady = '0;
      if (win >= 0) expReady[win] = 1'b1;
      rIdx  = rActive ? int'(tq[0].id[TW-1 -: 2]) : 0;
      expRv = '0;
      if (rActive) expRv[rIdx] = 1'b1;
      expRr = i_RREADY[rIdx];

      checkOutput("rnd_arready", i_ARREADY, expReady);
      checkOutput("rnd_arvalid", o_ARVALID, mBusy);
      if (mBusy) begin
        checkOutput("rnd_arid", o_ARID, mId);
        checkOutput("rnd_araddr", o_ARADDR, mAddr);
        checkOutput("rnd_arlen", o_ARLEN, mLen);
      end
      checkOutput("rnd_rvalid", i_RVALID, expRv);
      checkOutput("rnd_rready", o_RREADY, expRr);

      rHs = rActive && expRr;
      if (rHs) begin
        if (beat == tq[0].len) begin
          mCnt[rIdx]--;
          void'(tq.pop_front());
          beat = 0;
          rActive = 0;
        end else begin
          beat++;
        end
      end
      if (mBusy) begin
        if (o_ARREADY) begin
          mCnt[mIdx]++;
          mPtr  = (mIdx + 1) % N;
          mBusy = 0;
          tq.push_back('{mId, mLen});
        end
      end else if (win >= 0) begin
        mBusy = 1;
        mIdx  = win;
        mAddr = i_ARADDR[win*AW +: AW];
        mId   = {2'(win), i_ARID[win*IW +: IW]};
        mLen  = int'(i_ARLEN[win*8 +: 8]);
      end
      tick();
    end
    #3;
    for (int k = 0; k < N; k++) checkOutput("rnd_cnt_end", dut.cnt_q[k], mCnt[k]);
    checkOutput("rnd_riderr", rid_err, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
